csc_rgb2ycbcr_pipe: RTL and testbench
=====================================

// Module: csc_rgb2ycbcr_pipe
// PURPOSE
//  Parametrised RGB->YCbCr colour-space converter for the video pixel path, with valid/ready backpressure.
//  Per-pixel selectable matrix: BT.601 full range, BT.709 full range, BT.601 studio range, or bypass.
//  Rounds to nearest, clamps each output to both the low and high range limit, and counts clamped pixels.
//  Sits between the capture/unpack stage and the downstream chroma/compression stages.
// PARAMETERS
//  DW    8   bits per colour component, in and out (legal range 8..12)
//  TW    3   width of the sideband tag bus; tags travel with their pixel
//  FRAC  14  fractional bits of the signed coefficients (Q2.FRAC, 18-bit signed)
// PORTS
//  i_pclk     in   1     pixel clock; all logic is on the rising edge
//  i_rst      in   1     synchronous reset, active high
//  i_valid    in   1     input pixel valid
//  o_ready    out  1     block accepts the input pixel this cycle
//  i_R/i_G/i_B in  DW    unsigned RGB components
//  i_mode     in   2     0=601 full, 1=709 full, 2=601 studio, 3=bypass; sampled with the pixel
//  i_tags     in   TW    sideband (sof/eol/eof etc.), passed through unchanged
//  o_valid    out  1     output pixel valid
//  i_ready    in   1     downstream accepts the output pixel
//  o_Y/o_Cb/o_Cr out DW  converted components
//  o_tags     out  TW    tags aligned to the output pixel
//  o_sat      out  1     qualified by o_valid: at least one component of this pixel was clamped
//  i_sat_clr  in   1     synchronous clear of o_sat_cnt
//  o_sat_cnt  out  16    clamped-pixel count; stops at 16'hFFFF
// BEHAVIOUR
//  - Reset: o_valid=0, o_Y/o_Cb/o_Cr=0, o_tags=0, o_sat=0, o_sat_cnt=0; o_ready=1 from the first cycle after reset.
//  - Handshake: transfer on valid&ready at each side. 3-stage pipeline with a single global advance
//    enable, adv = ~o_valid | i_ready; o_ready = adv. Stalled stages hold their data.
//  - Latency is 3 cycles with no stall; throughput is 1 pixel/clk. No bubbles are inserted, none are lost.
//  - Once o_valid=1 and i_ready=0, o_Y/o_Cb/o_Cr/o_tags/o_sat stay stable until the transfer.
//  - Stage 1 registers the inputs and mode. Stage 2 forms the 9 signed products (DW+1 x 18).
//  - Stage 3: sum = K0*R + K1*G + K2*B + (OFF << FRAC) + (1 << (FRAC-1)). Arithmetic shift right by FRAC.
//    Clamp to [LO, HI], then register the result.
//  - Sum width: DW+21 bits signed; intermediate values never wrap.
//  - Full range: OFF_Y=0, OFF_C=2^(DW-1); LO=0, HI=2^DW-1 for all components.
//  - Studio: OFF_Y=16<<(DW-8); Y limits 16..235 and C limits 16..240, each scaled by <<(DW-8).
//  - Bypass (mode 3): Y=G, Cb=B, Cr=R, same latency, never flagged as clamped.
//  - o_sat_cnt increments once per transferred output pixel with o_sat=1.
//  - If i_sat_clr and an increment happen in the same cycle, the clear wins and the result is 0.
//  - Reset mid-operation: the pipeline is flushed and in-flight pixels are discarded; o_valid=0 on the next cycle.
//  - i_mode may change on any pixel; each pixel uses its own mode.
// STRUCTURE
//  - Package csc_pkg holds:
//    - the mode enum;
//    - the 4x3x3 coefficient table as signed [17:0] constants, Q2.14;
//    - the offset and limit tables, expressed for DW=8 and scaled in RTL.
//  - 601 coefficients: Y 4899/9617/1868; Cb -2765/-5427/8192; Cr 8192/-6860/-1332.
//  - 709 and studio coefficients are defined in csc_pkg.
//  - One sub-module, csc_mac3: 3-term signed multiply-add with rounding and clamp, instantiated x3.
//    It shares the stall enable with the parent.
// TESTING (DW=8, i_ready=1 unless stated)
//  - Mode 0: (255,255,255)->(255,128,128); (0,0,0)->(0,128,128).
//    Each output appears exactly 3 clocks after acceptance, and o_sat=0.
//  - Mode 0, red (255,0,0)->Y=76, Cb=85, Cr=255. Unclamped Cr is 256, so o_sat=1 and o_sat_cnt=1.
//  - Mode 2: white->(235,128,128), black->(16,128,128).
//    Mode 3, (10,20,30)->(Y=20, Cb=30, Cr=10).
//  - Backpressure: stream 8 pixels with tags 0..7 while i_ready toggles pseudo-randomly.
//    All 8 pixels arrive in order with matching tags, and outputs are stable while stalled.
//  - Assert i_rst with 3 pixels in flight: o_valid=0 next cycle, no stale pixel afterwards, o_sat_cnt=0.
//  - Apply 70000 clamped pixels: o_sat_cnt holds at 65535.
//    Pulse i_sat_clr in the same cycle as an increment: o_sat_cnt=0.

Source files
------------

// File: rtl/csc_pkg.sv
// Shared types and constant tables for the RGB->YCbCr converter.
// Coefficients are Q2.14 signed; offsets and limits are given for 8-bit
// components and scaled up to the configured component width in the RTL.
package csc_pkg;

   typedef enum logic [1:0] {
      MODE_601_FULL   = 2'd0,
      MODE_709_FULL   = 2'd1,
      MODE_601_STUDIO = 2'd2,
      MODE_BYPASS     = 2'd3
   } csc_mode_e;

   localparam int CSC_TAB_FRAC = 14;

   typedef logic signed [17:0] csc_coef_t;

   // Indexed [mode][output Y/Cb/Cr][input R/G/B].
   // Bypass routes G->Y, B->Cb, R->Cr through the same datapath with unity
   // gain, so it keeps the normal latency and can never leave the range.
   localparam csc_coef_t CSC_COEF [4][3][3] = '{
      '{ '{ 18'sd4899,  18'sd9617,  18'sd1868 },
         '{-18'sd2765, -18'sd5427,  18'sd8192 },
         '{ 18'sd8192, -18'sd6860, -18'sd1332 } },
      '{ '{ 18'sd3483,  18'sd11718, 18'sd1183 },
         '{-18'sd1877, -18'sd6315,  18'sd8192 },
         '{ 18'sd8192, -18'sd7441, -18'sd751  } },
      '{ '{ 18'sd4207,  18'sd8260,  18'sd1604 },
         '{-18'sd2428, -18'sd4768,  18'sd7196 },
         '{ 18'sd7196, -18'sd6026, -18'sd1170 } },
      '{ '{ 18'sd0,     18'sd16384, 18'sd0    },
         '{ 18'sd0,     18'sd0,     18'sd16384},
         '{ 18'sd16384, 18'sd0,     18'sd0    } }
   };

   // 8-bit offsets and clamp limits, indexed by mode.
   localparam int CSC_OFF_Y8 [4] = '{0,   0,   16,  0  };
   localparam int CSC_OFF_C8 [4] = '{128, 128, 128, 0  };
   localparam int CSC_LO_Y8  [4] = '{0,   0,   16,  0  };
   localparam int CSC_HI_Y8  [4] = '{255, 255, 235, 255};
   localparam int CSC_LO_C8  [4] = '{0,   0,   16,  0  };
   localparam int CSC_HI_C8  [4] = '{255, 255, 240, 255};

   // Scale an 8-bit level to dw bits; 255 means "full scale" and maps to all ones.
   function automatic int csc_scale(input int v8, input int dw);
      if (v8 == 255) return (1 << dw) - 1;
      return v8 << (dw - 8);
   endfunction

   // Re-express a Q2.14 table entry with frac fractional bits.
   function automatic csc_coef_t csc_rescale(input csc_coef_t k, input int frac);
      if (frac >= CSC_TAB_FRAC) return k <<< (frac - CSC_TAB_FRAC);
      return k >>> (CSC_TAB_FRAC - frac);
   endfunction

endpackage

// File: rtl/csc_mac3.sv
// Three-term signed multiply-add with round-to-nearest and clamp.
// Stage 2 holds the products (plus the offset/limits that travel with them),
// stage 3 holds the clamped result. Both advance on the parent's stall enable.
module csc_mac3
   import csc_pkg::*;
#(
   parameter int DW   = 8,
   parameter int FRAC = 14
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_adv,
   input  logic [DW-1:0] i_r,
   input  logic [DW-1:0] i_g,
   input  logic [DW-1:0] i_b,
   input  csc_coef_t     i_k0,
   input  csc_coef_t     i_k1,
   input  csc_coef_t     i_k2,
   input  logic [DW-1:0] i_off,
   input  logic [DW-1:0] i_lo,
   input  logic [DW-1:0] i_hi,
   output logic [DW-1:0] o_val,
   output logic          o_sat
);

   localparam int PW = DW + 19;
   localparam int SW = DW + 21;
   localparam logic signed [SW-1:0] RND = SW'(2 ** (FRAC - 1));

   logic signed [PW-1:0] r_p0, r_p1, r_p2;
   logic        [DW-1:0] r_off, r_lo, r_hi;
   logic signed [SW-1:0] w_sum, w_shr, w_lo_s, w_hi_s;
   logic        [DW-1:0] w_val;
   logic                 w_sat;
   logic        [DW-1:0] r_val;
   logic                 r_sat;

   // Stage 2: form the three products and carry this pixel's offset/limits.
   // NOTE: clocked state always uses <=, so every register samples pre-edge values.
   // NOTE: datapath registers carry no reset; only valid/outputs need a known value.
   always_ff @(posedge i_clk) begin
      if (i_adv) begin
         r_p0  <= PW'($signed({1'b0, i_r})) * PW'(i_k0);
         r_p1  <= PW'($signed({1'b0, i_g})) * PW'(i_k1);
         r_p2  <= PW'($signed({1'b0, i_b})) * PW'(i_k2);
         r_off <= i_off;
         r_lo  <= i_lo;
         r_hi  <= i_hi;
      end
   end

   // Stage 3 combinational: sum, round, arithmetic shift, clamp.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_sum  = SW'(r_p0) + SW'(r_p1) + SW'(r_p2)
             + (SW'($signed({1'b0, r_off})) <<< FRAC) + RND;
      w_shr  = w_sum >>> FRAC;
      w_lo_s = SW'($signed({1'b0, r_lo}));
      w_hi_s = SW'($signed({1'b0, r_hi}));
      w_val  = w_shr[DW-1:0];
      w_sat  = 1'b0;
      if (w_shr < w_lo_s) begin
         w_val = r_lo;
         w_sat = 1'b1;
      end else if (w_shr > w_hi_s) begin
         w_val = r_hi;
         w_sat = 1'b1;
      end
   end

   // Stage 3 register: the converted component seen at the block output.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_val <= '0;
         r_sat <= 1'b0;
      end else if (i_adv) begin
         r_val <= w_val;
         r_sat <= w_sat;
      end
   end

   assign o_val = r_val;
   assign o_sat = r_sat;

endmodule

// File: rtl/csc_rgb2ycbcr_pipe.sv
// RGB->YCbCr colour-space converter, 3-stage pipeline with valid/ready.
// One global advance enable moves every stage; a stalled output freezes the
// whole pipe, so no bubbles are added and no pixel is dropped.
module csc_rgb2ycbcr_pipe
   import csc_pkg::*;
#(
   parameter int DW   = 8,
   parameter int TW   = 3,
   parameter int FRAC = 14
) (
   input  logic          i_pclk,
   input  logic          i_rst,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [DW-1:0] i_R,
   input  logic [DW-1:0] i_G,
   input  logic [DW-1:0] i_B,
   input  logic [1:0]    i_mode,
   input  logic [TW-1:0] i_tags,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [DW-1:0] o_Y,
   output logic [DW-1:0] o_Cb,
   output logic [DW-1:0] o_Cr,
   output logic [TW-1:0] o_tags,
   output logic          o_sat,
   input  logic          i_sat_clr,
   output logic [15:0]   o_sat_cnt
);

   logic          w_adv;
   logic          r1_valid, r2_valid, r3_valid;
   logic [DW-1:0] r1_r, r1_g, r1_b;
   csc_mode_e     r1_mode;
   logic [TW-1:0] r1_tags, r2_tags, r3_tags;
   csc_coef_t     w_k   [3][3];
   logic [DW-1:0] w_off [3];
   logic [DW-1:0] w_lo  [3];
   logic [DW-1:0] w_hi  [3];
   logic [DW-1:0] w_val [3];
   logic [2:0]    w_sat;
   logic [15:0]   r_sat_cnt;

   assign w_adv   = ~r3_valid | i_ready;
   assign o_ready = w_adv;

   // Valid pipeline; reset flushes every in-flight pixel.
   always_ff @(posedge i_pclk) begin
      if (i_rst) begin
         r1_valid <= 1'b0;
         r2_valid <= 1'b0;
         r3_valid <= 1'b0;
      end else if (w_adv) begin
         r1_valid <= i_valid;
         r2_valid <= r1_valid;
         r3_valid <= r2_valid;
      end
   end

   // Stage 1 capture of components, mode and tags; tags ride along to stage 2.
   always_ff @(posedge i_pclk) begin
      if (w_adv) begin
         r1_r    <= i_R;
         r1_g    <= i_G;
         r1_b    <= i_B;
         r1_mode <= csc_mode_e'(i_mode);
         r1_tags <= i_tags;
         r2_tags <= r1_tags;
      end
   end

   // Output tags are visible at the port, so they return to zero on reset.
   always_ff @(posedge i_pclk) begin
      if (i_rst) r3_tags <= '0;
      else if (w_adv) r3_tags <= r2_tags;
   end

   // Per-pixel coefficient, offset and limit selection from the stage-1 mode.
   always_comb begin
      for (int c = 0; c < 3; c++) begin
         for (int t = 0; t < 3; t++) begin
            w_k[c][t] = csc_rescale(CSC_COEF[r1_mode][c][t], FRAC);
         end
      end
      w_off[0] = DW'(csc_scale(CSC_OFF_Y8[r1_mode], DW));
      w_lo[0]  = DW'(csc_scale(CSC_LO_Y8[r1_mode], DW));
      w_hi[0]  = DW'(csc_scale(CSC_HI_Y8[r1_mode], DW));
      for (int c = 1; c < 3; c++) begin
         w_off[c] = DW'(csc_scale(CSC_OFF_C8[r1_mode], DW));
         w_lo[c]  = DW'(csc_scale(CSC_LO_C8[r1_mode], DW));
         w_hi[c]  = DW'(csc_scale(CSC_HI_C8[r1_mode], DW));
      end
   end

   for (genvar c = 0; c < 3; c++) begin : g_mac
      csc_mac3 #(
         .DW   (DW),
         .FRAC (FRAC)
      ) u_mac (
         .i_clk (i_pclk),
         .i_rst (i_rst),
         .i_adv (w_adv),
         .i_r   (r1_r),
         .i_g   (r1_g),
         .i_b   (r1_b),
         .i_k0  (w_k[c][0]),
         .i_k1  (w_k[c][1]),
         .i_k2  (w_k[c][2]),
         .i_off (w_off[c]),
         .i_lo  (w_lo[c]),
         .i_hi  (w_hi[c]),
         .o_val (w_val[c]),
         .o_sat (w_sat[c])
      );
   end

   // Clamped-pixel counter: clear beats increment, saturates at all ones.
   always_ff @(posedge i_pclk) begin
      if (i_rst || i_sat_clr) begin
         r_sat_cnt <= '0;
      end else if (r3_valid && i_ready && (|w_sat) && !(&r_sat_cnt)) begin
         r_sat_cnt <= r_sat_cnt + 16'd1;
      end
   end

   assign o_valid   = r3_valid;
   assign o_Y       = w_val[0];
   assign o_Cb      = w_val[1];
   assign o_Cr      = w_val[2];
   assign o_tags    = r3_tags;
   assign o_sat     = |w_sat;
   assign o_sat_cnt = r_sat_cnt;

endmodule

// File: tb/tb_csc_rgb2ycbcr_pipe.sv
// Directed bench for csc_rgb2ycbcr_pipe at DW=8, TW=3.
// Inputs change on the falling edge; outputs are sampled just after it.
module tb_csc_rgb2ycbcr_pipe;

   logic        i_pclk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic        o_ready;
   logic [7:0]  i_R, i_G, i_B;
   logic [1:0]  i_mode;
   logic [2:0]  i_tags;
   logic        o_valid;
   logic        i_ready;
   logic [7:0]  o_Y, o_Cb, o_Cr;
   logic [2:0]  o_tags;
   logic        o_sat;
   logic        i_sat_clr;
   logic [15:0] o_sat_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   csc_rgb2ycbcr_pipe #(.DW(8), .TW(3), .FRAC(14)) dut (
      .i_pclk    (i_pclk),
      .i_rst     (i_rst),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_R       (i_R),
      .i_G       (i_G),
      .i_B       (i_B),
      .i_mode    (i_mode),
      .i_tags    (i_tags),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_Y       (o_Y),
      .o_Cb      (o_Cb),
      .o_Cr      (o_Cr),
      .o_tags    (o_tags),
      .o_sat     (o_sat),
      .i_sat_clr (i_sat_clr),
      .o_sat_cnt (o_sat_cnt)
   );

   always #5 i_pclk = ~i_pclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One isolated pixel: measure latency and compare the converted result.
   task automatic run_one(input string name, input logic [1:0] m,
                          input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input logic [7:0] ey, input logic [7:0] ecb, input logic [7:0] ecr,
                          input logic es);
      int lat;
      @(negedge i_pclk);
      i_valid = 1'b1; i_mode = m; i_R = r; i_G = g; i_B = b; i_tags = 3'd5;
      @(posedge i_pclk);
      lat = 1;
      @(negedge i_pclk);
      i_valid = 1'b0;
      while (!o_valid && lat < 10) begin
         @(posedge i_pclk);
         lat++;
         @(negedge i_pclk);
      end
      check({name, "_latency"}, 32'(lat), 32'd3);
      check({name, "_Y"},   32'(o_Y),   32'(ey));
      check({name, "_Cb"},  32'(o_Cb),  32'(ecb));
      check({name, "_Cr"},  32'(o_Cr),  32'(ecr));
      check({name, "_sat"}, 32'(o_sat), 32'(es));
      check({name, "_tag"}, 32'(o_tags), 32'd5);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] pat;
      int sent, recv, stale, seen;
      logic [7:0] ev [3];

      i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_sat_clr = 1'b0;
      i_R = '0; i_G = '0; i_B = '0; i_mode = '0; i_tags = '0;

      // Reset state
      repeat (3) @(posedge i_pclk);
      @(negedge i_pclk);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_Y",     32'(o_Y),     32'd0);
      check("rst_Cb",    32'(o_Cb),    32'd0);
      check("rst_Cr",    32'(o_Cr),    32'd0);
      check("rst_tags",  32'(o_tags),  32'd0);
      check("rst_sat",   32'(o_sat),   32'd0);
      check("rst_cnt",   32'(o_sat_cnt), 32'd0);
      i_rst = 1'b0;
      @(negedge i_pclk);
      check("rst_ready", 32'(o_ready), 32'd1);

      // Directed conversions
      run_one("m0_white", 2'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd128, 8'd128, 1'b0);
      run_one("m0_black", 2'd0, 8'd0,   8'd0,   8'd0,   8'd0,   8'd128, 8'd128, 1'b0);
      run_one("m0_red",   2'd0, 8'd255, 8'd0,   8'd0,   8'd76,  8'd85,  8'd255, 1'b1);
      @(negedge i_pclk);
      check("cnt_after_red", 32'(o_sat_cnt), 32'd1);
      run_one("m1_white", 2'd1, 8'd255, 8'd255, 8'd255, 8'd255, 8'd128, 8'd128, 1'b0);
      run_one("m1_red",   2'd1, 8'd255, 8'd0,   8'd0,   8'd54,  8'd99,  8'd255, 1'b1);
      @(negedge i_pclk);
      check("cnt_after_red709", 32'(o_sat_cnt), 32'd2);
      run_one("m2_white", 2'd2, 8'd255, 8'd255, 8'd255, 8'd235, 8'd128, 8'd128, 1'b0);
      run_one("m2_black", 2'd2, 8'd0,   8'd0,   8'd0,   8'd16,  8'd128, 8'd128, 1'b0);
      run_one("m3_bypass", 2'd3, 8'd10, 8'd20,  8'd30,  8'd20,  8'd30,  8'd10,  1'b0);

      // Backpressure: even pixels are mode-0 greys, odd pixels are bypass.
      pat  = 32'hB26C_9D35;
      sent = 0;
      recv = 0;
      for (int cyc = 0; cyc < 200 && recv < 8; cyc++) begin
         @(negedge i_pclk);
         i_ready = pat[cyc % 32];
         if (sent < 8) begin
            i_valid = 1'b1;
            i_tags  = 3'(sent);
            if (sent % 2 == 0) begin
               i_mode = 2'd0;
               i_R = 8'(sent * 30); i_G = 8'(sent * 30); i_B = 8'(sent * 30);
            end else begin
               i_mode = 2'd3;
               i_R = 8'(sent * 7 + 3); i_G = 8'(sent * 11 + 5); i_B = 8'(sent * 13 + 1);
            end
         end else begin
            i_valid = 1'b0;
         end
         #1;
         if (o_valid) begin
            if (recv % 2 == 0) begin
               ev[0] = 8'(recv * 30); ev[1] = 8'd128; ev[2] = 8'd128;
            end else begin
               ev[0] = 8'(recv * 11 + 5); ev[1] = 8'(recv * 13 + 1); ev[2] = 8'(recv * 7 + 3);
            end
            check("bp_Y",   32'(o_Y),    32'(ev[0]));
            check("bp_Cb",  32'(o_Cb),   32'(ev[1]));
            check("bp_Cr",  32'(o_Cr),   32'(ev[2]));
            check("bp_tag", 32'(o_tags), 32'(recv));
            if (i_ready) recv++;
         end
         if (i_valid && o_ready) sent++;
      end
      check("bp_received", 32'(recv), 32'd8);
      i_ready = 1'b1;
      i_valid = 1'b0;
      stale = 0;
      repeat (5) begin
         @(negedge i_pclk);
         if (o_valid) stale++;
      end
      check("bp_no_extra", 32'(stale), 32'd0);

      // Reset with three pixels in flight
      i_mode = 2'd0; i_R = 8'd255; i_G = 8'd0; i_B = 8'd0;
      for (int k = 0; k < 3; k++) begin
         @(negedge i_pclk);
         i_valid = 1'b1;
         i_tags  = 3'(k);
      end
      @(negedge i_pclk);
      i_valid = 1'b0;
      i_rst   = 1'b1;
      @(negedge i_pclk);
      check("midrst_valid", 32'(o_valid),   32'd0);
      check("midrst_cnt",   32'(o_sat_cnt), 32'd0);
      check("midrst_Y",     32'(o_Y),       32'd0);
      i_rst = 1'b0;
      stale = 0;
      repeat (8) begin
         @(negedge i_pclk);
         if (o_valid) stale++;
      end
      check("midrst_no_stale", 32'(stale), 32'd0);

      // Counter saturation with 70000 clamped pixels
      @(negedge i_pclk);
      i_valid = 1'b1;
      repeat (70000) @(posedge i_pclk);
      @(negedge i_pclk);
      i_valid = 1'b0;
      repeat (4) @(negedge i_pclk);
      check("cnt_saturated", 32'(o_sat_cnt), 32'd65535);

      // Plain clear, then clear coinciding with an increment
      i_sat_clr = 1'b1;
      @(negedge i_pclk);
      i_sat_clr = 1'b0;
      check("cnt_cleared", 32'(o_sat_cnt), 32'd0);
      seen = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge i_pclk);
         i_valid   = (cyc < 4);
         i_sat_clr = 1'b0;
         #1;
         if (o_valid) begin
            seen++;
            if (seen == 3) begin
               check("cnt_before_clr", 32'(o_sat_cnt), 32'd2);
               i_sat_clr = 1'b1;
            end else if (seen == 4) begin
               check("cnt_clr_wins", 32'(o_sat_cnt), 32'd0);
            end
         end
      end
      check("clr_outputs_seen", 32'(seen), 32'd4);
      check("cnt_after_clr", 32'(o_sat_cnt), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
